// File: rtl/sevenseg_pkg.sv
// Shared constants, segment patterns and converter state type for the
// seven-segment scan driver and its binary-to-BCD converter.
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} patterns for decimal digits 0..9
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'd0:    seg = SEG_DIGIT[0];
            4'd1:    seg = SEG_DIGIT[1];
            4'd2:    seg = SEG_DIGIT[2];
            4'd3:    seg = SEG_DIGIT[3];
            4'd4:    seg = SEG_DIGIT[4];
            4'd5:    seg = SEG_DIGIT[5];
            4'd6:    seg = SEG_DIGIT[6];
            4'd7:    seg = SEG_DIGIT[7];
            4'd8:    seg = SEG_DIGIT[8];
            4'd9:    seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: samples value, runs VALUE_W shift steps,
// then pulses commit for one clock with the finished BCD and overflow flag.
module bin2bcd_seq
    import sevenseg_pkg::*;
#(
    parameter int VALUE_W    = 32,
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VALUE_W-1:0]      value,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic                    overflow,
    output logic                    commit,
    output logic                    busy
);

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          CNT_W   = $clog2(VALUE_W + 1);
    localparam logic [63:0] MAX_VAL = pow10(NUM_DIGITS) - 64'd1;

    conv_state_t        state_reg, state_next;
    logic [VALUE_W-1:0] shift_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ovf_reg;
    logic               busy_reg;

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = SHIFT;
            SHIFT:   if (cnt_reg == CNT_W'(VALUE_W - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    shift_reg <= value;
                    bcd_reg   <= '0;
                    cnt_reg   <= '0;
                    ovf_reg   <= (64'(value) > MAX_VAL);
                    busy_reg  <= 1'b1;
                end
                SHIFT: begin
                    bcd_reg   <= {bcd_adj[BCD_W-2:0], shift_reg[VALUE_W-1]};
                    shift_reg <= {shift_reg[VALUE_W-2:0], 1'b0};
                    cnt_reg   <= cnt_reg + 1'b1;
                end
                COMMIT:  busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bcd      = bcd_reg;
    assign overflow = ovf_reg;
    assign commit   = (state_reg == COMMIT);
    assign busy     = busy_reg;

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Stopwatch display end: BCD conversion into a tear-free digit register and a
// refresh scanner driving the multiplexed active-low an/seg/dp outputs.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int REFRESH_HZ    = 8_000,
    parameter int NUM_DIGITS    = 8,
    parameter int VALUE_W       = 32,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  busy,
    output logic                  overflow
);

    localparam int DIV   = CLK_HZ / REFRESH_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BCD_W = 4 * NUM_DIGITS;

    logic [BCD_W-1:0]      conv_bcd;
    logic                  conv_ovf;
    logic                  conv_commit;

    logic [BCD_W-1:0]      digit_reg;
    logic                  ovf_reg;
    logic [PRE_W-1:0]      pre_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic                  armed_reg;
    logic [NUM_DIGITS-1:0] an_reg;
    logic [6:0]            seg_reg;
    logic                  dp_reg;

    logic                  tick;
    logic [NUM_DIGITS:1]   lead_zero;
    logic [6:0]            digit_seg [NUM_DIGITS];

    bin2bcd_seq #(
        .VALUE_W    (VALUE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .bcd      (conv_bcd),
        .overflow (conv_ovf),
        .commit   (conv_commit),
        .busy     (busy)
    );

    // lead_zero[i]: digit i and every digit above it are zero (top bit is a sentinel)
    assign lead_zero[NUM_DIGITS] = 1'b1;

    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] nib;
        assign nib = digit_reg[4*gi +: 4];
        if (gi == 0) begin : g_first
            assign digit_seg[gi] = ovf_reg ? SEG_DASH : seg_decode(nib);
        end else begin : g_rest
            assign lead_zero[gi]  = (nib == 4'd0) & lead_zero[gi+1];
            assign digit_seg[gi]  = ovf_reg ? SEG_DASH :
                                    ((BLANK_LEADING != 0) && lead_zero[gi]) ? SEG_BLANK :
                                    seg_decode(nib);
        end
    end

    assign tick = (pre_reg == PRE_W'(DIV - 1));

    // The first tick only arms the scanner so that digit 0 is the first one lit.
    always_ff @(posedge clk) begin
        if (reset) begin
            digit_reg <= '0;
            ovf_reg   <= 1'b0;
            pre_reg   <= '0;
            idx_reg   <= '0;
            armed_reg <= 1'b0;
            an_reg    <= '1;
            seg_reg   <= SEG_BLANK;
            dp_reg    <= 1'b1;
        end else begin
            if (conv_commit) begin
                digit_reg <= conv_bcd;
                ovf_reg   <= conv_ovf;
            end
            if (tick) begin
                pre_reg   <= '0;
                armed_reg <= 1'b1;
                if (armed_reg) begin
                    idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
                end
            end else begin
                pre_reg <= pre_reg + 1'b1;
            end
            if (tick || !armed_reg) begin
                an_reg  <= '1;
                seg_reg <= SEG_BLANK;
                dp_reg  <= 1'b1;
            end else begin
                an_reg  <= ~(NUM_DIGITS'(1) << idx_reg);
                seg_reg <= digit_seg[idx_reg];
                dp_reg  <= ~dp_mask[idx_reg];
            end
        end
    end

    assign an       = an_reg;
    assign seg      = seg_reg;
    assign dp       = dp_reg;
    assign overflow = ovf_reg;

endmodule
